// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port arbiter: FSM state codes,
// owner codes and default datapath types.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam int MASK_W_DEF = 8;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [MASK_W_DEF-1:0] mask_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_fetch_line_buf.sv
// One-entry fetch line buffer (tag, data, valid) used by mem_port_arbiter.
// Only present when FETCH_BUF_EN is defined.
`ifdef FETCH_BUF_EN
module mem_port_arbiter_fetch_line_buf #(
    parameter int TAG_W  = 61,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    input  logic              fill_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              inv_i,
    input  logic [TAG_W-1:0]  inv_tag_i,
    input  logic              inv_all_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign hit_o  = valid_q & (lookup_tag_i == tag_q);
    assign data_o = data_q;

    // Invalidation wins over fill so a stale line can never survive a store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (inv_all_i | (inv_i & valid_q & (inv_tag_i == tag_q))) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
            valid_q <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one multi-cycle memory port and
// produces the core stall. Optional fetch line buffer: define FETCH_BUF_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              stall,
    output logic              err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic              d_req_s;
    logic              d_grant_s;
    logic              f_grant_s;
    logic              timeout_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic              buf_hit_s;
    logic [DATA_W-1:0] buf_rdata_s;
    logic              unused_s;

    // A requester whose done pulse is showing this cycle is not re-granted yet.
    assign d_req_s      = d_re | d_we;
    assign d_grant_s    = d_req_s & ~d_done_q;
    assign f_grant_s    = if_req & ~if_done_q;
    assign timeout_s    = (state_q == ST_WAIT) & ~mem_resp_valid & (cnt_q == CNT_LAST);
    assign fetch_addr_s = {if_addr[ADDR_W-1:3], 3'b000};
    assign unused_s     = ^if_addr[2:0];

`ifdef FETCH_BUF_EN
    logic buf_fill_s;
    logic buf_inv_s;

    assign buf_fill_s = (state_q == ST_WAIT) & mem_resp_valid & (owner_q == OWN_FETCH);
    assign buf_inv_s  = (state_q == ST_ISSUE) & mem_req_ready & we_q & (owner_q == OWN_DATA);

    mem_port_arbiter_fetch_line_buf #(
        .TAG_W  (ADDR_W - 3),
        .DATA_W (DATA_W)
    ) u_fetch_line_buf (
        .clk          (clk),
        .rst          (rst),
        .lookup_tag_i (if_addr[ADDR_W-1:3]),
        .fill_i       (buf_fill_s),
        .fill_tag_i   (addr_q[ADDR_W-1:3]),
        .fill_data_i  (mem_resp_rdata),
        .inv_i        (buf_inv_s),
        .inv_tag_i    (addr_q[ADDR_W-1:3]),
        .inv_all_i    (timeout_s),
        .hit_o        (buf_hit_s),
        .data_o       (buf_rdata_s)
    );
`else
    assign buf_hit_s   = 1'b0;
    assign buf_rdata_s = '0;
`endif

    // Next-state logic: grant, issue handshake, response capture and timeout.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        cnt_d      = cnt_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (d_grant_s) begin
                    // Simultaneous read and write is executed as a write and flagged.
                    owner_d = OWN_DATA;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_we ? d_wdata : '0;
                    wmask_d = d_we ? d_wmask : '0;
                    err_d   = err_q | (d_re & d_we);
                    state_d = ST_ISSUE;
                end else if (f_grant_s & buf_hit_s) begin
                    if_done_d  = 1'b1;
                    if_rdata_d = buf_rdata_s;
                end else if (f_grant_s) begin
                    owner_d = OWN_FETCH;
                    we_d    = 1'b0;
                    addr_d  = fetch_addr_s;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_DATA) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = we_q ? d_rdata_q : mem_resp_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_resp_rdata;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_DATA) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_FETCH;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt_q      <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            cnt_q      <= cnt_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign if_done       = if_done_q;
    assign d_done        = d_done_q;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign err           = err_q;
    assign stall         = (if_req & ~if_done_q) | (d_req_s & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT=4); FETCH_BUF_EN selects the
// buffered-fetch expectations.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct packed {
        logic        is_data;
        logic [63:0] rdata;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        d_re;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        stall;
    logic        err;

    int    n_checks = 0;
    int    n_errs   = 0;
    int    n_memreq = 0;
    int    ready_delay = 0;
    bit    resp_en  = 1'b1;
    bit    resp_due = 1'b0;
    bit    stray    = 1'b0;
    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    logic [63:0] resp_data_q[$];

    mem_port_arbiter #(
        .ADDR_W (64), .DATA_W (64), .MASK_W (8), .TIMEOUT (4)
    ) dut (
        .clk (clk), .rst (rst),
        .if_req (if_req), .if_addr (if_addr), .if_done (if_done), .if_rdata (if_rdata),
        .d_re (d_re), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_wmask (d_wmask), .d_done (d_done), .d_rdata (d_rdata),
        .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
        .mem_req_we (mem_req_we), .mem_req_addr (mem_req_addr),
        .mem_req_wdata (mem_req_wdata), .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid), .mem_resp_rdata (mem_resp_rdata),
        .stall (stall), .err (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_data, input int max_cyc, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            tick();
            cyc++;
            seen = is_data ? d_done : if_done;
        end
        if (!seen) check_val("done_budget", 64'd0, 64'd1);
    endtask

    task automatic push_req(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.wmask = wm;
        exp_req_q.push_back(r);
    endtask

    task automatic push_done(input logic is_data, input logic [63:0] rd);
        done_t e;
        e.is_data = is_data; e.rdata = rd;
        exp_done_q.push_back(e);
    endtask

    // Memory model: ready after ready_delay cycles of valid, response one cycle after accept.
    initial begin
        int hold;
        hold = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'd0;
        forever begin
            tick();
            mem_resp_valid = 1'b0;
            mem_resp_rdata = 64'd0;
            if (resp_due) begin
                resp_due = 1'b0;
                if (resp_en) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = (resp_data_q.size() > 0) ? resp_data_q.pop_front() : 64'd0;
                end
            end
            if (stray) begin
                stray = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
            end
            if (mem_req_valid) begin
                mem_req_ready = (hold >= ready_delay);
                hold++;
            end else begin
                hold = 0;
                mem_req_ready = 1'b0;
            end
        end
    end

    // Scoreboard: accepted requests and done pulses against the expectation queues.
    initial begin
        req_t  r;
        done_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_req_valid && mem_req_ready) begin
                    n_memreq++;
                    resp_due = 1'b1;
                    if (exp_req_q.size() == 0) begin
                        check_val("unexpected_req", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        r = exp_req_q.pop_front();
                        check_val("req_we", {63'd0, mem_req_we}, {63'd0, r.we});
                        check_val("req_addr", mem_req_addr, r.addr);
                        check_val("req_wdata", mem_req_wdata, r.wdata);
                        check_val("req_wmask", {56'd0, mem_req_wmask}, {56'd0, r.wmask});
                    end
                end
                if (if_done || d_done) begin
                    if (exp_done_q.size() == 0) begin
                        check_val("unexpected_done", {62'd0, d_done, if_done}, 64'd0);
                    end else begin
                        e = exp_done_q.pop_front();
                        check_val("done_kind", {63'd0, d_done}, {63'd0, e.is_data});
                        check_val("done_rdata", d_done ? d_rdata : if_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        rst = 1'b0; if_req = 1'b0; if_addr = 64'd0;
        d_re = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0; d_wmask = 8'd0;
        repeat (3) tick();
        check_val("rst_valid", {63'd0, mem_req_valid}, 64'd0);
        check_val("rst_done", {62'd0, if_done, d_done}, 64'd0);
        check_val("rst_err", {63'd0, err}, 64'd0);
        check_val("rst_addr", mem_req_addr, 64'd0);
        check_val("rst_rdata", if_rdata | d_rdata, 64'd0);
        rst = 1'b1;
        tick();

        // Fetch latency: c0 request, c1 valid, c2 response, c3 done.
        if_req = 1'b1; if_addr = 64'h1004;
        push_req(1'b0, 64'h1000, 64'd0, 8'd0);
        resp_data_q.push_back(64'hDEADBEEF00000013);
        push_done(1'b0, 64'hDEADBEEF00000013);
        #1 check_val("f_stall_c0", {63'd0, stall}, 64'd1);
        tick();
        check_val("f_valid_c1", {63'd0, mem_req_valid}, 64'd1);
        check_val("f_addr_c1", mem_req_addr, 64'h1000);
        check_val("f_stall_c1", {63'd0, stall}, 64'd1);
        tick();
        check_val("f_stall_c2", {63'd0, stall}, 64'd1);
        check_val("f_done_c2", {63'd0, if_done}, 64'd0);
        tick();
        check_val("f_done_c3", {63'd0, if_done}, 64'd1);
        check_val("f_rdata_c3", if_rdata, 64'hDEADBEEF00000013);
        check_val("f_stall_c3", {63'd0, stall}, 64'd0);
        if_req = 1'b0;
        tick();

        // Simultaneous fetch and load: data goes first, exactly two requests.
        base = n_memreq;
        if_req = 1'b1; if_addr = 64'h1008; d_re = 1'b1; d_addr = 64'h2000;
        push_req(1'b0, 64'h2000, 64'd0, 8'd0);
        push_req(1'b0, 64'h1008, 64'd0, 8'd0);
        resp_data_q.push_back(64'h0123_4567_89AB_CDEF);
        resp_data_q.push_back(64'h1111_2222_3333_4444);
        push_done(1'b1, 64'h0123_4567_89AB_CDEF);
        push_done(1'b0, 64'h1111_2222_3333_4444);
        wait_done(1'b1, 20, cyc);
        d_re = 1'b0;
        wait_done(1'b0, 20, cyc);
        if_req = 1'b0;
        repeat (3) tick();
        check_val("two_reqs", n_memreq - base, 64'd2);

        // Store leaves d_rdata at the last load value.
        d_we = 1'b1; d_addr = 64'h3008; d_wdata = 64'h0000_0000_0000_00AB; d_wmask = 8'h01;
        push_req(1'b1, 64'h3008, 64'h0000_0000_0000_00AB, 8'h01);
        resp_data_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        push_done(1'b1, 64'h0123_4567_89AB_CDEF);
        tick();
        check_val("st_we", {63'd0, mem_req_we}, 64'd1);
        wait_done(1'b1, 20, cyc);
        d_we = 1'b0; d_wmask = 8'd0;
        tick();

        // Back-pressure: request held 5 cycles, requester drops mid-ISSUE.
        ready_delay = 5;
        if_req = 1'b1; if_addr = 64'h4000;
        push_req(1'b0, 64'h4000, 64'd0, 8'd0);
        resp_data_q.push_back(64'h4444_0000_4444_0000);
        push_done(1'b0, 64'h4444_0000_4444_0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", {63'd0, mem_req_valid}, 64'd1);
            check_val("bp_addr", mem_req_addr, 64'h4000);
            if (i == 2) if_req = 1'b0;
            tick();
        end
        check_val("bp_valid6", {63'd0, mem_req_valid}, 64'd1);
        wait_done(1'b0, 10, cyc);
        ready_delay = 0;
        tick();

        // Timeout after 4 WAIT cycles.
        resp_en = 1'b0;
        d_re = 1'b1; d_addr = 64'h5000;
        push_req(1'b0, 64'h5000, 64'd0, 8'd0);
        push_done(1'b1, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_val("to_err_early", {63'd0, err}, 64'd0);
            check_val("to_done_early", {63'd0, d_done}, 64'd0);
        end
        tick();
        check_val("to_done", {63'd0, d_done}, 64'd1);
        check_val("to_err", {63'd0, err}, 64'd1);
        d_re = 1'b0;
        repeat (3) tick();
        check_val("err_sticky", {63'd0, err}, 64'd1);

        // Reset in WAIT clears everything; a later stray response is ignored.
        if_req = 1'b1; if_addr = 64'h6000;
        push_req(1'b0, 64'h6000, 64'd0, 8'd0);
        repeat (3) tick();
        rst = 1'b0; if_req = 1'b0;
        #1;
        check_val("mrst_valid", {63'd0, mem_req_valid}, 64'd0);
        check_val("mrst_err", {63'd0, err}, 64'd0);
        check_val("mrst_addr", mem_req_addr, 64'd0);
        check_val("mrst_rdata", if_rdata | d_rdata, 64'd0);
        tick();
        rst = 1'b1;
        resp_en = 1'b1;
        tick();
        stray = 1'b1;
        repeat (4) tick();
        check_val("stray_valid", {63'd0, mem_req_valid}, 64'd0);

        // Fetch line buffer behaviour (or plain memory fetches without it).
        if_req = 1'b1; if_addr = 64'h1000;
        push_req(1'b0, 64'h1000, 64'd0, 8'd0);
        resp_data_q.push_back(64'hABCD_0000_0000_1000);
        push_done(1'b0, 64'hABCD_0000_0000_1000);
        wait_done(1'b0, 20, cyc);
        if_req = 1'b0;
        tick();
        base = n_memreq;
        if_req = 1'b1; if_addr = 64'h1004;
`ifdef FETCH_BUF_EN
        push_done(1'b0, 64'hABCD_0000_0000_1000);
        wait_done(1'b0, 5, cyc);
        check_val("hit_latency", cyc, 64'd1);
        check_val("hit_no_req", {63'd0, mem_req_valid}, 64'd0);
`else
        push_req(1'b0, 64'h1000, 64'd0, 8'd0);
        resp_data_q.push_back(64'hABCD_0000_0000_2000);
        push_done(1'b0, 64'hABCD_0000_0000_2000);
        wait_done(1'b0, 20, cyc);
`endif
        if_req = 1'b0;
        repeat (2) tick();
`ifdef FETCH_BUF_EN
        check_val("hit_memreqs", n_memreq - base, 64'd0);
`else
        check_val("nobuf_memreqs", n_memreq - base, 64'd1);
`endif
        d_we = 1'b1; d_addr = 64'h1000; d_wdata = 64'h7777; d_wmask = 8'hFF;
        push_req(1'b1, 64'h1000, 64'h7777, 8'hFF);
        resp_data_q.push_back(64'd0);
        push_done(1'b1, 64'd0);
        wait_done(1'b1, 20, cyc);
        d_we = 1'b0; d_wmask = 8'd0;
        tick();
        if_req = 1'b1; if_addr = 64'h1004;
        push_req(1'b0, 64'h1000, 64'd0, 8'd0);
        resp_data_q.push_back(64'hABCD_0000_0000_3000);
        push_done(1'b0, 64'hABCD_0000_0000_3000);
        wait_done(1'b0, 20, cyc);
        if_req = 1'b0;
        tick();

        // Read and write together: executed as a write, err raised.
        check_val("rw_err_before", {63'd0, err}, 64'd0);
        d_re = 1'b1; d_we = 1'b1; d_addr = 64'h7000; d_wdata = 64'h1234; d_wmask = 8'hF0;
        push_req(1'b1, 64'h7000, 64'h1234, 8'hF0);
        resp_data_q.push_back(64'h9999);
        push_done(1'b1, 64'd0);
        wait_done(1'b1, 20, cyc);
        d_re = 1'b0; d_we = 1'b0;
        check_val("rw_err", {63'd0, err}, 64'd1);
        repeat (3) tick();

        check_val("req_q_empty", exp_req_q.size(), 64'd0);
        check_val("done_q_empty", exp_done_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
